// File: rtl/color_frame_ctrl_pkg.sv
// Shared encodings and sizes for the colour-frame classifier.
// Frame class and FSM state types, frame geometry, and the saturating count helper.
package color_frame_ctrl_pkg;

    localparam int COUNT_W = 15;
    localparam int FRAME_W = 176;
    localparam int FRAME_H = 144;

    typedef logic [COUNT_W-1:0] count_t;

    localparam count_t COUNT_MAX = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_RED  = 2'b01,
        CLS_BLUE = 2'b10
    } frame_class_e;

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_ACCUM     = 2'd1,
        ST_DECIDE    = 2'd2,
        ST_FILTER    = 2'd3
    } state_e;

    function automatic count_t sat_inc(input count_t v, input logic inc);
        if (inc && (v != COUNT_MAX)) begin
            return v + count_t'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/color_frame_ctrl_pixel_classifier.sv
// Combinational RGB332 pixel classifier: flags strongly red or strongly blue pixels.
module pixel_classifier (
    input  logic [7:0] pixel,
    output logic       is_red,
    output logic       is_blue
);

    logic [2:0] r;
    logic [1:0] b;
    logic       unused_green;

    assign r = pixel[7:5];
    assign b = pixel[1:0];
    // Green plays no part in the red/blue decision.
    assign unused_green = ^pixel[4:2];

    assign is_red  = (r >= 3'd5) && (b <= 2'd1);
    assign is_blue = (b >= 2'd2) && (r <= 3'd2);

endmodule

// File: rtl/color_frame_ctrl.sv
// Per-frame red/blue pixel counter with frame classification and a one-deep report register.
// Optional report debouncing is enabled by defining COLOR_FRAME_DEBOUNCE_EN.
module color_frame_ctrl
    import color_frame_ctrl_pkg::*;
#(
    parameter logic [COUNT_W-1:0] RED_THRESH      = 15'd12672,
    parameter logic [COUNT_W-1:0] BLUE_THRESH     = 15'd12672,
    parameter int unsigned        DEBOUNCE_FRAMES = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [7:0]         PIXEL_IN,
    input  logic               PIXEL_VALID,
    input  logic               VGA_VSYNC_NEG,
    input  logic               RESULT_ACK,
    output logic [1:0]         RESULT,
    output logic               RESULT_VALID,
    output logic               OVERRUN,
    output logic [COUNT_W-1:0] RED_COUNT,
    output logic [COUNT_W-1:0] BLUE_COUNT
);

    localparam logic [2:0] DEB_N = 3'(DEBOUNCE_FRAMES);

    state_e       state_q, state_d;
    logic         vsync_q, vsync_d;
    count_t       red_acc_q, red_acc_d, blue_acc_q, blue_acc_d;
    count_t       red_cnt_q, red_cnt_d, blue_cnt_q, blue_cnt_d;
    frame_class_e cls_q, cls_d, result_q, result_d, prev_cls_q, prev_cls_d;
    logic         valid_q, valid_d, overrun_q, overrun_d;
    logic [2:0]   deb_cnt_q, deb_cnt_d;
`ifdef COLOR_FRAME_DEBOUNCE_EN
    frame_class_e last_rep_q, last_rep_d;
`endif

    logic   is_red, is_blue, vsync_edge, count_en, report_gen;
    count_t red_inc, blue_inc;

    pixel_classifier u_classifier (
        .pixel   (PIXEL_IN),
        .is_red  (is_red),
        .is_blue (is_blue)
    );

    function automatic frame_class_e classify(input count_t red, input count_t blue);
        if ((red >= RED_THRESH) && (red >= blue)) return CLS_RED;
        if (blue >= BLUE_THRESH) return CLS_BLUE;
        return CLS_NONE;
    endfunction

    assign vsync_edge = VGA_VSYNC_NEG && !vsync_q;
    assign count_en   = PIXEL_VALID && (state_q != ST_WAIT_SYNC);
    assign red_inc    = sat_inc(red_acc_q, count_en && is_red);
    assign blue_inc   = sat_inc(blue_acc_q, count_en && is_blue);

    always_comb begin
        state_d    = state_q;
        vsync_d    = VGA_VSYNC_NEG;
        red_acc_d  = red_inc;
        blue_acc_d = blue_inc;
        red_cnt_d  = red_cnt_q;
        blue_cnt_d = blue_cnt_q;
        cls_d      = cls_q;
        result_d   = result_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        deb_cnt_d  = deb_cnt_q;
        prev_cls_d = prev_cls_q;
        report_gen = 1'b0;
`ifdef COLOR_FRAME_DEBOUNCE_EN
        last_rep_d = last_rep_q;
`endif

        unique case (state_q)
            ST_WAIT_SYNC: begin
                red_acc_d  = '0;
                blue_acc_d = '0;
                if (vsync_edge) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (vsync_edge) begin
                    red_cnt_d  = red_inc;
                    blue_cnt_d = blue_inc;
                    red_acc_d  = '0;
                    blue_acc_d = '0;
                    state_d    = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                cls_d   = classify(red_cnt_q, blue_cnt_q);
                state_d = ST_FILTER;
            end
            ST_FILTER: begin
                // The run counter saturates at the target so "count reached" is a simple equality.
                if ((deb_cnt_q != 3'd0) && (cls_q == prev_cls_q)) begin
                    deb_cnt_d = (deb_cnt_q >= DEB_N) ? DEB_N : deb_cnt_q + 3'd1;
                end else begin
                    deb_cnt_d = 3'd1;
                end
                prev_cls_d = cls_q;
`ifdef COLOR_FRAME_DEBOUNCE_EN
                report_gen = (deb_cnt_d == DEB_N) && (cls_q != last_rep_q);
                if (report_gen) last_rep_d = cls_q;
`else
                report_gen = 1'b1;
`endif
                state_d = ST_ACCUM;
            end
            default: state_d = ST_WAIT_SYNC;
        endcase

        // An unacknowledged report is never overwritten; the newer one is dropped.
        if (report_gen) begin
            if (!valid_q || RESULT_ACK) begin
                result_d = cls_q;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (RESULT_ACK && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_WAIT_SYNC;
            vsync_q    <= 1'b0;
            red_acc_q  <= '0;
            blue_acc_q <= '0;
            red_cnt_q  <= '0;
            blue_cnt_q <= '0;
            cls_q      <= CLS_NONE;
            result_q   <= CLS_NONE;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            deb_cnt_q  <= 3'd0;
            prev_cls_q <= CLS_NONE;
`ifdef COLOR_FRAME_DEBOUNCE_EN
            last_rep_q <= CLS_NONE;
`endif
        end else begin
            state_q    <= state_d;
            vsync_q    <= vsync_d;
            red_acc_q  <= red_acc_d;
            blue_acc_q <= blue_acc_d;
            red_cnt_q  <= red_cnt_d;
            blue_cnt_q <= blue_cnt_d;
            cls_q      <= cls_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            deb_cnt_q  <= deb_cnt_d;
            prev_cls_q <= prev_cls_d;
`ifdef COLOR_FRAME_DEBOUNCE_EN
            last_rep_q <= last_rep_d;
`endif
        end
    end

    assign RESULT       = result_q;
    assign RESULT_VALID = valid_q;
    assign OVERRUN      = overrun_q;
    assign RED_COUNT    = red_cnt_q;
    assign BLUE_COUNT   = blue_cnt_q;

endmodule

// File: doc/color_frame_ctrl.md
COLOR_FRAME_CTRL -- requirements
Module: color_frame_ctrl

Interface
REQ-001 SHALL have parameter RED_THRESH, 15'd12672, minimum red-pixel count for a RED frame.
REQ-002 SHALL have parameter BLUE_THRESH, 15'd12672, minimum blue-pixel count for a BLUE frame.
REQ-003 SHALL have parameter DEBOUNCE_FRAMES, 3, consecutive equal frame classes required before reporting (range 1..7).
REQ-004 SHALL have port CLK  in  1  single system clock; all logic on posedge.
REQ-005 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have port PIXEL_IN  in  8  RGB332 pixel: R=[7:5], G=[4:2], B=[1:0].
REQ-007 SHALL have port PIXEL_VALID  in  1  PIXEL_IN is a real pixel this cycle.
REQ-008 SHALL have port VGA_VSYNC_NEG  in  1  frame sync; rising edge marks end of frame.
REQ-009 SHALL have port RESULT_ACK  in  1  consumer accepts RESULT this cycle.
REQ-010 SHALL have port RESULT  out  2  2'b00 NONE, 2'b01 RED, 2'b10 BLUE; 2'b11 never driven.
REQ-011 SHALL have port RESULT_VALID  out  1  RESULT holds an unacknowledged report.
REQ-012 SHALL have port OVERRUN  out  1  sticky: a report was dropped while RESULT_VALID was high.
REQ-013 SHALL have ports RED_COUNT and BLUE_COUNT  out  15 each  latched counts of last completed frame.

Function
REQ-014 Pixel classification SHALL be: red iff R>=5 and B<=1; blue iff B>=2 and R<=2; otherwise neither; red and blue are mutually exclusive.
REQ-015 Accumulators SHALL increment only when PIXEL_VALID=1 and state is ACCUM, DECIDE or FILTER; they SHALL saturate at 15'h7FFF.
REQ-016 VSYNC edge SHALL be detected as current sample 1 and previous registered sample 0; cycle N = the edge detecting cycle.
REQ-017 FSM states SHALL be WAIT_SYNC, ACCUM, DECIDE, FILTER.
REQ-018 WAIT_SYNC: accumulators held at 0; on edge -> ACCUM (partial first frame discarded, no report).
REQ-019 ACCUM: on edge at cycle N, RED_COUNT/BLUE_COUNT SHALL load accumulator values (including a pixel valid at cycle N), accumulators clear to 0, -> DECIDE.
REQ-020 DECIDE (cycle N+1): frame class SHALL be RED if red>=RED_THRESH and red>=blue; else BLUE if blue>=BLUE_THRESH; else NONE; -> FILTER.
REQ-021 FILTER (cycle N+2): debounce update and report load per REQ-024..026; -> ACCUM.
REQ-022 VSYNC edges during DECIDE or FILTER SHALL be ignored.
REQ-023 Minimum latency SHALL be RESULT_VALID high at the clock edge ending cycle N+2 (visible cycle N+3).
REQ-024 Report load: if RESULT_VALID=0 or RESULT_ACK=1 in the load cycle, RESULT SHALL take the new class and RESULT_VALID stays/goes 1.
REQ-025 If RESULT_VALID=1 and RESULT_ACK=0 in the load cycle, the report SHALL be dropped, RESULT unchanged, OVERRUN set to 1.
REQ-026 RESULT_ACK with RESULT_VALID=1 and no load SHALL clear RESULT_VALID next edge; RESULT_ACK with RESULT_VALID=0 SHALL be ignored.
REQ-027 RESULT SHALL not change while RESULT_VALID=1 except via REQ-024.

Reset
REQ-028 RESET SHALL force: state WAIT_SYNC, accumulators 0, RED_COUNT 0, BLUE_COUNT 0, RESULT 2'b00, RESULT_VALID 0, OVERRUN 0, debounce counter 0, last-reported class NONE, VSYNC history 0.
REQ-029 RESET mid-frame SHALL discard the frame; RESET has priority over all other events.

Configuration
REQ-030 Macro COLOR_FRAME_DEBOUNCE_EN defined: a report SHALL be generated only when the same class is seen DEBOUNCE_FRAMES consecutive frames and differs from last reported class; a differing class restarts the 3-bit count at 1.
REQ-031 Macro undefined: every frame class SHALL generate a report in FILTER; DEBOUNCE_FRAMES unused.

Structure
REQ-032 Shared package SHALL hold class encodings (NONE/RED/BLUE), FSM state encodings, frame size constants 176x144, and the 15-bit count width.
REQ-033 One sub-module pixel_classifier (combinational, PIXEL_IN -> is_red, is_blue) SHALL be used.

Verification
REQ-034 Reset, one edge, then 13000 red (8'hE0) valid pixels, edge -> RED_COUNT=13000, BLUE_COUNT=0, debounce off: RESULT=01, RESULT_VALID at N+3.
REQ-035 Frame of 13000 blue (8'h03) plus 100 red pixels -> RESULT=10; frame of 8'h1C only -> RESULT=00.
REQ-036 Debounce on, DEBOUNCE_FRAMES=3, frames RED,RED,BLUE,RED,RED,RED -> single report RED after frame 6, none before.
REQ-037 Two reports without RESULT_ACK -> first RESULT kept, OVERRUN=1; ACK in same cycle as load -> new RESULT, RESULT_VALID stays 1, OVERRUN stays 0.
REQ-038 40000 red pixels in one frame -> RED_COUNT=32767; RESET asserted mid-frame -> all outputs zero, next edge produces no report.
